// File: rtl/pipe_ctrl.sv
// Stall/flush controller for the in-order N-stage core: hazard arbitration, multi-cycle wait FSM.
// Optional PIPE_CTRL_PERF_EN builds the stall-cycle and flush performance counters.
module pipe_ctrl #(
  parameter int NSTAGE    = 5,
  parameter int EX_STAGE  = 2,
  parameter int MEM_STAGE = 3,
  parameter int MC_MAX    = 64,
  parameter int CNT_W     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_for_load,
  input  logic              br_taken,
  input  logic              stallreq_for_ex,
  input  logic              mc_done,
  input  logic              mem_busy,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] bubble,
  output logic              mc_busy,
  output logic              mc_timeout,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flushes
);

  typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MC_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_MAX - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             pend_done_q;
  logic             timeout_q;
  logic             in_wait;
  logic             hit_max;
  logic             done_now;
  int               hi;

  assign in_wait  = (state_q == MC_WAIT);
  // Timeout fires on the cycle whose increment would bring the count to MC_MAX.
  assign hit_max  = in_wait && !mem_busy && (cnt_q >= CNT_LAST);
  assign done_now = in_wait && !mem_busy && (mc_done || pend_done_q || hit_max);
  assign cnt_d    = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;

  always_comb begin
    stall  = '0;
    bubble = '0;
    hi     = -1;
    if (mem_busy) begin
      hi = MEM_STAGE;
    end else if (in_wait) begin
      hi = EX_STAGE;
    end else if (br_taken) begin
      for (int i = 1; i <= EX_STAGE; i++) bubble[i] = 1'b1;
    end else if (stallreq_for_load) begin
      hi = 1;
    end
    for (int i = 0; i < NSTAGE; i++) begin
      if (i <= hi) stall[i] = 1'b1;
      if (hi >= 0 && i == hi + 1) bubble[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      pend_done_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (stallreq_for_ex) begin
            state_q <= MC_WAIT;
            cnt_q   <= '0;
          end
        end
        MC_WAIT: begin
          if (!mem_busy) cnt_q <= cnt_d;
          if (mc_done && mem_busy) pend_done_q <= 1'b1;
          if (hit_max) timeout_q <= 1'b1;
          if (done_now) begin
            state_q     <= RUN;
            pend_done_q <= 1'b0;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign mc_busy    = in_wait;
  assign mc_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;
  logic        flush_now;

  // A redirect is only honoured when neither SRAM wait nor a multi-cycle wait masks it.
  assign flush_now = !in_wait && !mem_busy && br_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall[0]) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush_now) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flush_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_flushes      = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed scenarios then random hazards against a reference model.
module tb_pipe_ctrl;
  localparam int NS  = 5;
  localparam int EX  = 2;
  localparam int MEM = 3;
  localparam int MCM = 16;
  localparam int CW  = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld = 1'b0, br = 1'b0, exq = 1'b0, dn = 1'b0, mb = 1'b0;
  logic [NS-1:0] stall, bubble;
  logic          mc_busy, mc_timeout;
  logic [31:0]   perf_stall_cycles, perf_flushes;

  always #5 clk = ~clk;

  pipe_ctrl #(.NSTAGE(NS), .EX_STAGE(EX), .MEM_STAGE(MEM), .MC_MAX(MCM), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .stallreq_for_load(ld), .br_taken(br), .stallreq_for_ex(exq),
    .mc_done(dn), .mem_busy(mb),
    .stall(stall), .bubble(bubble), .mc_busy(mc_busy), .mc_timeout(mc_timeout),
    .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
  );

  typedef struct {
    logic [NS-1:0] st;
    logic [NS-1:0] bb;
    logic          busy;
    logic          tmo;
    logic          pend;
    logic [31:0]   pst;
    logic [31:0]   pfl;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: whether a multi-cycle op is outstanding, how long it has waited, etc.
  bit          m_wait = 0, m_pend = 0, m_tmo = 0;
  int          m_wcnt = 0;
  logic [31:0] m_pst = 0, m_pfl = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit i_ld, input bit i_br, input bit i_ex,
                     input bit i_dn, input bit i_mb, input bit i_rst);
    exp_t e;
    int   hi;
    bit   done, to;
    @(posedge clk);
    #1;
    ld = i_ld; br = i_br; exq = i_ex; dn = i_dn; mb = i_mb; rst = i_rst;
    e.st = '0;
    e.bb = '0;
    hi = -1;
    if (i_mb) hi = MEM;
    else if (m_wait) hi = EX;
    else if (i_br) e.bb = NS'(((1 << (EX + 1)) - 1) & ~1);
    else if (i_ld) hi = 1;
    if (hi >= 0) begin
      e.st = NS'((1 << (hi + 1)) - 1);
      if (hi + 1 < NS) e.bb = NS'(1 << (hi + 1));
    end
    e.busy = m_wait;
    e.tmo  = m_tmo;
    e.pend = m_pend;
`ifdef PIPE_CTRL_PERF_EN
    e.pst = m_pst;
    e.pfl = m_pfl;
`else
    e.pst = 32'd0;
    e.pfl = 32'd0;
`endif
    if (!i_rst) sbq.push_back(e);
    if (i_rst) begin
      m_wait = 0; m_pend = 0; m_tmo = 0; m_wcnt = 0; m_pst = 0; m_pfl = 0;
    end else begin
      m_pst = m_pst + 32'(e.st[0]);
      if (!m_wait) begin
        if (i_br && !i_mb) m_pfl = m_pfl + 1;
        if (i_ex) begin
          m_wait = 1;
          m_wcnt = 0;
        end
      end else begin
        to   = !i_mb && (m_wcnt + 1 >= MCM);
        done = !i_mb && (i_dn || m_pend);
        if (i_mb && i_dn) m_pend = 1;
        if (!i_mb && m_wcnt < MCM) m_wcnt = m_wcnt + 1;
        if (to) m_tmo = 1;
        if (done || to) begin
          m_wait = 0;
          m_pend = 0;
        end
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("stall", 32'(stall), 32'(e.st));
        chk("bubble", 32'(bubble), 32'(e.bb));
        chk("stall_bubble_overlap", 32'(stall & bubble), 32'd0);
        chk("mc_busy", 32'(mc_busy), 32'(e.busy));
        chk("mc_timeout", 32'(mc_timeout), 32'(e.tmo));
        chk("pend_done", 32'(dut.pend_done_q), 32'(e.pend));
        chk("perf_stall_cycles", perf_stall_cycles, e.pst);
        chk("perf_flushes", perf_flushes, e.pfl);
      end
    end
  end

  initial begin : driver
    // Reset with every input high, then release with inputs low.
    cyc(1, 1, 1, 1, 1, 1);
    cyc(1, 1, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    // Load-use for one cycle.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // Branch together with load-use.
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // Multi-cycle op finishing after ten wait cycles.
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // mc_done lands while the SRAM is busy.
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) cyc(0, 0, 0, (i == 6), (i >= 5 && i <= 8), 0);
    cyc(0, 0, 0, 0, 0, 0);
    // Timeout with no mc_done, sticky until reset.
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < MCM + 4; i++) cyc((i % 3) == 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    // Randomised hazard mix.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(99) < 20, $urandom_range(99) < 15, $urandom_range(99) < 6,
          $urandom_range(99) < 10, $urandom_range(99) < 15, $urandom_range(999) < 5);
    end
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
